// File: rtl/cc_hit_line_serializer.sv
// Hit-line buffer feeding the interconnect R channel as 8-beat, 64-bit wrap bursts starting at the critical word.
// Optional: define CC_SER_STALL_CNT_EN to add the stall_cnt_o saturating sink-stall counter.
module cc_hit_line_serializer #(
  parameter int DEPTH           = 2,
  parameter int AFULL_THRESHOLD = DEPTH - 1,
  parameter int ID_W            = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            line_valid_i,
  output logic            line_ready_o,
  input  logic [511:0]    line_data_i,
  input  logic [2:0]      line_offset_i,
  input  logic [ID_W-1:0] line_id_i,
  output logic            afull_o,
  output logic            empty_o,
  output logic [ID_W-1:0] inct_rid_o,
  output logic [63:0]     inct_rdata_o,
  output logic [1:0]      inct_rresp_o,
  output logic            inct_rlast_o,
  output logic            inct_rvalid_o,
  input  logic            inct_rready_i
`ifdef CC_SER_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt_o
`endif
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW + 1)'(AFULL_THRESHOLD);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [2:0]      offset;
    logic [511:0]    data;
  } line_t;

  line_t          r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic [2:0]     r_cnt;

  line_t          w_head;
  logic [2:0]     w_word_idx;
  logic           w_push;
  logic           w_beat;
  logic           w_pop;

  // Flags come straight from occupancy so the request decoder sees them without an extra cycle.
  assign empty_o      = (r_count == '0);
  assign afull_o      = (r_count >= AFULL_C);
  assign line_ready_o = (r_count != DEPTH_C);

  assign w_head     = r_mem[r_rd_ptr];
  assign w_word_idx = w_head.offset + r_cnt;

  assign inct_rvalid_o = !empty_o;
  assign inct_rid_o    = w_head.id;
  assign inct_rdata_o  = w_head.data[{w_word_idx, 6'd0} +: 64];
  assign inct_rresp_o  = 2'b00;
  assign inct_rlast_o  = inct_rvalid_o && (r_cnt == 3'd7);

  // NOTE: combinational block assigns every output a default first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_push = 1'b0;
    w_beat = 1'b0;
    w_pop  = 1'b0;
    if (line_valid_i && line_ready_o) w_push = 1'b1;
    if (inct_rvalid_o && inct_rready_i) begin
      w_beat = 1'b1;
      w_pop  = (r_cnt == 3'd7);
    end
  end

  // NOTE: line storage is deliberately not reset; only pointers and occupancy define what is valid, which keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{id: line_id_i, offset: line_offset_i, data: line_data_i};
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // Beat counter wraps 7 -> 0 on its own, which coincides with the head pop.
      if (w_beat) r_cnt <= r_cnt + 3'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef CC_SER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (inct_rvalid_o && !inct_rready_i && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  // Stall counter absent in this build; the R path is unchanged.
`endif

endmodule

// File: tb/tb_cc_hit_line_serializer.sv
// Directed bench for cc_hit_line_serializer: wrap order, back-to-back bursts, full/drop, stall, push-on-pop, async reset.
module tb_cc_hit_line_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         line_valid_i = 1'b0;
  logic         line_ready_o;
  logic [511:0] line_data_i = '0;
  logic [2:0]   line_offset_i = '0;
  logic [3:0]   line_id_i = '0;
  logic         afull_o;
  logic         empty_o;
  logic [3:0]   inct_rid_o;
  logic [63:0]  inct_rdata_o;
  logic [1:0]   inct_rresp_o;
  logic         inct_rlast_o;
  logic         inct_rvalid_o;
  logic         inct_rready_i = 1'b0;
`ifdef CC_SER_STALL_CNT_EN
  logic [15:0]  stall_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cc_hit_line_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .line_valid_i  (line_valid_i),
    .line_ready_o  (line_ready_o),
    .line_data_i   (line_data_i),
    .line_offset_i (line_offset_i),
    .line_id_i     (line_id_i),
    .afull_o       (afull_o),
    .empty_o       (empty_o),
    .inct_rid_o    (inct_rid_o),
    .inct_rdata_o  (inct_rdata_o),
    .inct_rresp_o  (inct_rresp_o),
    .inct_rlast_o  (inct_rlast_o),
    .inct_rvalid_o (inct_rvalid_o),
    .inct_rready_i (inct_rready_i)
`ifdef CC_SER_STALL_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] l;
    for (int w = 0; w < 8; w++) l[64*w +: 64] = base + 64'(w);
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] base, input logic [2:0] off, input logic [3:0] id);
    line_valid_i  = 1'b1;
    line_data_i   = mk_line(base);
    line_offset_i = off;
    line_id_i     = id;
    step();
    line_valid_i  = 1'b0;
  endtask

  // Expects beats first..last of a line, with rready already high; advances one edge per beat.
  task automatic beats(input string tag, input logic [63:0] base, input logic [2:0] off,
                       input logic [3:0] id, input int first, input int last);
    logic [2:0] idx;
    for (int i = first; i <= last; i++) begin
      idx = off + 3'(i);
      check({tag, "_rvalid"}, 64'(inct_rvalid_o), 64'd1);
      check({tag, "_rdata"},  inct_rdata_o, base + 64'(idx));
      check({tag, "_rid"},    64'(inct_rid_o), 64'(id));
      check({tag, "_rlast"},  64'(inct_rlast_o), 64'(i == 7));
      check({tag, "_rresp"},  64'(inct_rresp_o), 64'd0);
      step();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rvalid"}, 64'(inct_rvalid_o), 64'd0);
    check({tag, "_rlast"},  64'(inct_rlast_o), 64'd0);
    check({tag, "_empty"},  64'(empty_o), 64'd1);
    check({tag, "_afull"},  64'(afull_o), 64'd0);
    check({tag, "_ready"},  64'(line_ready_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check_idle("rst_async");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("rst_done");

    // Offset 0, words 0..7, id 3
    inct_rready_i = 1'b1;
    push(64'h0, 3'd0, 4'h3);
    beats("off0", 64'h0, 3'd0, 4'h3, 0, 7);
    check_idle("off0_after");

    // Offset 5 wrap order 5,6,7,0,1,2,3,4
    push(64'h100, 3'd5, 4'h1);
    beats("off5", 64'h100, 3'd5, 4'h1, 0, 7);
    check("off5_empty", 64'(empty_o), 64'd1);

    // Fill both entries with sink stalled; third line must be dropped
    inct_rready_i = 1'b0;
    push(64'h200, 3'd0, 4'h1);
    check("fill1_afull", 64'(afull_o), 64'd1);
    check("fill1_ready", 64'(line_ready_o), 64'd1);
    push(64'h300, 3'd2, 4'h2);
    check("full_ready", 64'(line_ready_o), 64'd0);
    check("full_afull", 64'(afull_o), 64'd1);
    check("full_empty", 64'(empty_o), 64'd0);
    push(64'h400, 3'd0, 4'h7);
    check("drop_ready", 64'(line_ready_o), 64'd0);
    check("drop_hold_rdata", inct_rdata_o, 64'h200);
    check("drop_hold_rid", 64'(inct_rid_o), 64'h1);
    inct_rready_i = 1'b1;
    beats("b2bA", 64'h200, 3'd0, 4'h1, 0, 7);
    beats("b2bB", 64'h300, 3'd2, 4'h2, 0, 7);
    check_idle("drop_absent");

    // Stall during beat 2; counter starts from a fresh reset
    rst = 1'b1;
    #1;
    check_idle("rst2");
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(64'h500, 3'd0, 4'h5);
    beats("stl_pre", 64'h500, 3'd0, 4'h5, 0, 1);
    inct_rready_i = 1'b0;
    check("stall0_rdata", inct_rdata_o, 64'h502);
    step();
    check("stall1_rdata", inct_rdata_o, 64'h502);
    check("stall1_rvalid", 64'(inct_rvalid_o), 64'd1);
    check("stall1_rlast", 64'(inct_rlast_o), 64'd0);
    step();
    check("stall2_rdata", inct_rdata_o, 64'h502);
    check("stall2_rid", 64'(inct_rid_o), 64'h5);
`ifdef CC_SER_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt_o), 64'd2);
`endif
    inct_rready_i = 1'b1;
    beats("stl_post", 64'h500, 3'd0, 4'h5, 2, 7);
    check_idle("stl_after");
`ifdef CC_SER_STALL_CNT_EN
    check("stall_cnt_end", 64'(stall_cnt_o), 64'd2);
`endif

    // Push coincident with pop of the last beat
    push(64'h600, 3'd0, 4'h6);
    beats("pp_C", 64'h600, 3'd0, 4'h6, 0, 6);
    check("pp_last_rdata", inct_rdata_o, 64'h607);
    check("pp_last_rlast", 64'(inct_rlast_o), 64'd1);
    push(64'h700, 3'd3, 4'h9);
    check("pp_empty", 64'(empty_o), 64'd0);
    check("pp_afull", 64'(afull_o), 64'd1);
    check("pp_ready", 64'(line_ready_o), 64'd1);
    beats("pp_D", 64'h700, 3'd3, 4'h9, 0, 7);
    check_idle("pp_after");

    // Async reset during beat 3 aborts the burst
    push(64'h800, 3'd1, 4'h4);
    beats("ar_pre", 64'h800, 3'd1, 4'h4, 0, 2);
    check("ar_beat3", inct_rdata_o, 64'h804);
    #2;
    rst = 1'b1;
    #1;
    check_idle("ar_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("ar_rel");
    push(64'h900, 3'd6, 4'hA);
    beats("ar_fresh", 64'h900, 3'd6, 4'hA, 0, 7);
    check_idle("ar_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
